frac_clkgen: RTL and testbench
==============================

Name: frac_clkgen

Overview:
Parametrised multi-channel fractional clock-enable generator on a single fast clock. Replaces fixed-frequency PLL outputs for slow core clocks: each channel's phase accumulator produces a one-cycle enable pulse and a square-wave MSB at refclk*inc/2^ACC_W. Increments are reprogrammable at run time, and a change takes effect glitch-free at that channel's next period boundary. A locked flag reports a settled configuration.

Parameters:
NUM_CLOCKS, 2, number of output channels (1..8)
ACC_W, 24, accumulator/increment width in bits
LOCK_CYCLES, 16, undisturbed cycles before locked asserts (>=1)
INC_DEFAULT, {24'd3756093, 24'd8388608}, packed NUM_CLOCKS*ACC_W reset increments; channel i is at [i*ACC_W +: ACC_W]

Ports:
refclk  input  1  sole clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset), sampled on refclk
sync  input  1  phase-align strobe for all channels
cfg_valid  input  1  config request
cfg_ready  output  1  config accepted when cfg_valid & cfg_ready
cfg_chan  input  3  target channel index
cfg_inc  input  ACC_W  new increment for target channel
cfg_err  output  1  one-cycle pulse: accepted request had cfg_chan >= NUM_CLOCKS
ce_out  output  NUM_CLOCKS  per-channel one-cycle enable pulse
clk_out  output  NUM_CLOCKS  per-channel square wave (accumulator MSB)
locked  output  1  configuration settled

Behaviour:
- Reset (rst=0 at edge): acc[i]=0, inc_act[i]=INC_DEFAULT[i], pend[i] cleared, ce_out=0, clk_out=0, cfg_err=0, locked=0, lock_cnt=0. Reset mid-operation drops any pending config.
- Per cycle, per channel (sync=0): {carry,acc}=acc+inc_act, mod 2^ACC_W. ce_out[i] is the registered carry, so it is high exactly one cycle, the cycle after the wrapping edge. clk_out[i] is the registered new acc MSB.
- inc_act[i]==0: channel stopped. acc holds, ce_out[i]=0, clk_out[i] holds.
- Config handshake: cfg_ready = !pend_valid[cfg_chan] (combinational); it is 1 for an out-of-range channel. On accept with a valid channel: pend_inc[chan]<=cfg_inc, pend_valid[chan]<=1. On accept with an invalid channel: no state change; cfg_err=1 next cycle.
- Pending apply: at the edge where channel i's add carries, or immediately at the next edge if inc_act[i]==0, set inc_act[i]<=pend_inc[i] and clear pend_valid[i]. The wrapping add still uses the old inc, so no short or long period is produced. An accept and an apply on the same channel in the same cycle cannot occur, because ready is low while pending.
- sync=1 (priority over accumulate): all acc<=0, ce_out<=0, clk_out<=0. All pending increments are applied immediately. Config accepts in the same cycle are still registered as pending.
- Lock: a disturbance is any apply or sync at an edge. A disturbance sets lock_cnt<=0 and locked<=0. Otherwise lock_cnt increments, saturating at LOCK_CYCLES, and locked<=(lock_cnt+1==LOCK_CYCLES) or already saturated. After reset release, locked rises at the 16th edge when the default is used.
- Channels are fully independent except for the shared sync and the shared locked flag.

Test Plan:
- Reset release, defaults, ACC_W=24: ch0 inc=8388608 gives ce_out[0] every 2nd cycle and clk_out[0] toggling each cycle. ch1 gives 3756093 pulses per 2^24 cycles (±1 over any window). locked=1 exactly 16 cycles after rst goes 1.
- Reprogram ch0 to 4194304 mid-period: cfg_ready drops, and the old 2-cycle period completes. From the next carry onward the period is 4 (clk_out 2 high / 2 low). locked drops at the apply and returns 16 cycles later.
- cfg_chan=5, NUM_CLOCKS=2: the request is accepted, cfg_err pulses exactly once, and no channel changes.
- Write inc=0 to ch1: after the next carry, ce_out[1] stays 0. Writing 8388608 while stopped applies next edge and pulsing resumes within 2 cycles.
- sync pulse with ch0 and ch1 at arbitrary phase and one pending write: all acc clear and the pending inc applies at once. Both channels then wrap at the identical cycle when incs are equal, and locked restarts its count.
- rst=0 asserted while a config is pending: after release inc_act=INC_DEFAULT, cfg_ready=1, and no stale apply occurs.

Source files
------------

// File: rtl/frac_clkgen.sv
// rtl/frac_clkgen.sv - multi-channel fractional clock-enable generator
// Phase accumulators produce ce/square-wave outputs at refclk*inc/2^ACC_W with boundary-aligned reprogramming.
module frac_clkgen #(
    parameter int NUM_CLOCKS  = 2,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] INC_DEFAULT = {24'd3756093, 24'd8388608}
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  sync,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_chan,
    input  logic [ACC_W-1:0]      cfg_inc,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] ce_out,
    output logic [NUM_CLOCKS-1:0] clk_out,
    output logic                  locked
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    logic [ACC_W-1:0]      r_acc      [NUM_CLOCKS];
    logic [ACC_W-1:0]      r_inc_act  [NUM_CLOCKS];
    logic [ACC_W-1:0]      r_pend_inc [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] r_pend_valid;
    logic [NUM_CLOCKS-1:0] r_ce;
    logic [NUM_CLOCKS-1:0] r_clk;
    logic                  r_err;
    logic                  r_locked;
    logic [LCW-1:0]        r_lock_cnt;

    logic [ACC_W:0]        w_sum [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] w_carry;
    logic [NUM_CLOCKS-1:0] w_apply;
    logic [NUM_CLOCKS-1:0] w_sel;
    logic                  w_ready;
    logic                  w_chan_ok;
    logic                  w_accept;
    logic                  w_disturb;

    // Out-of-range channels match no select bit, so they are always ready.
    always_comb begin
        w_sel   = '0;
        w_ready = 1'b1;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (cfg_chan == 3'(i)) begin
                w_sel[i] = 1'b1;
                w_ready  = !r_pend_valid[i];
            end
        end
    end

    assign w_chan_ok = |w_sel;
    assign w_accept  = cfg_valid & w_ready;
    assign cfg_ready = w_ready;

    // A pending increment lands on the wrapping edge, so the period in flight finishes with the old value.
    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            w_sum[i]   = {1'b0, r_acc[i]} + {1'b0, r_inc_act[i]};
            w_carry[i] = w_sum[i][ACC_W];
            w_apply[i] = r_pend_valid[i] &
                         (sync | w_carry[i] | (r_inc_act[i] == '0));
        end
    end

    assign w_disturb = sync | (|w_apply);

    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (!rst) begin
                r_acc[i]        <= '0;
                r_inc_act[i]    <= INC_DEFAULT[i*ACC_W +: ACC_W];
                r_pend_inc[i]   <= '0;
                r_pend_valid[i] <= 1'b0;
                r_ce[i]         <= 1'b0;
                r_clk[i]        <= 1'b0;
            end else begin
                if (sync) begin
                    r_acc[i] <= '0;
                    r_ce[i]  <= 1'b0;
                    r_clk[i] <= 1'b0;
                end else begin
                    r_acc[i] <= w_sum[i][ACC_W-1:0];
                    r_ce[i]  <= w_carry[i];
                    r_clk[i] <= w_sum[i][ACC_W-1];
                end
                if (w_accept && w_sel[i]) begin
                    r_pend_inc[i]   <= cfg_inc;
                    r_pend_valid[i] <= 1'b1;
                end else if (w_apply[i]) begin
                    r_inc_act[i]    <= r_pend_inc[i];
                    r_pend_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & !w_chan_ok;
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (w_disturb) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (r_lock_cnt != LCW'(LOCK_CYCLES)) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
            r_locked   <= (r_lock_cnt + 1'b1 == LCW'(LOCK_CYCLES));
        end else begin
            r_locked   <= 1'b1;
        end
    end

    assign ce_out  = r_ce;
    assign clk_out = r_clk;
    assign cfg_err = r_err;
    assign locked  = r_locked;

endmodule

// File: tb/tb_frac_clkgen.sv
// tb/tb_frac_clkgen.sv - scoreboard bench for frac_clkgen
// Stimulus queues hand-computed expectations per cycle; a negedge monitor pops and compares them.
module tb_frac_clkgen;

    logic        refclk;
    logic        rst;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_chan;
    logic [23:0] cfg_inc;
    logic        cfg_err;
    logic [1:0]  ce_out;
    logic [1:0]  clk_out;
    logic        locked;

    frac_clkgen #(
        .NUM_CLOCKS (2),
        .ACC_W      (24),
        .LOCK_CYCLES(16),
        .INC_DEFAULT({24'd3756093, 24'd8388608})
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_inc  (cfg_inc),
        .cfg_err  (cfg_err),
        .ce_out   (ce_out),
        .clk_out  (clk_out),
        .locked   (locked)
    );

    typedef struct {
        int    t;
        int    kind;
        int    idx;
        int    val;
        string name;
    } exp_t;

    exp_t  q[$];
    int    tick = 0;
    int    t0 = 0;
    int    checks = 0;
    int    failures = 0;
    int    ce1_cnt = 0;
    bit    done = 0;
    string kn[6] = '{"ce", "clk", "locked", "ready", "err", "ce1cnt"};

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    always @(posedge refclk) tick <= tick + 1;

    task automatic ex(input int k, input int kind, input int idx, input int val);
        exp_t e;
        int   pos;
        e.t    = t0 + k;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        e.name = $sformatf("%s%0d_k%0d", kn[kind], idx, k);
        pos = q.size();
        for (int j = 0; j < q.size(); j++) begin
            if (q[j].t > e.t) begin
                pos = j;
                break;
            end
        end
        q.insert(pos, e);
    endtask

    task automatic go_to(input int k);
        while (tick < t0 + k) begin
            @(posedge refclk);
            #1;
        end
    endtask

    always @(negedge refclk) begin
        exp_t e;
        int   act;
        if (!rst) ce1_cnt = 0;
        else      ce1_cnt += int'(ce_out[1]);
        while (q.size() > 0 && (q[0].t <= tick || done)) begin
            e = q.pop_front();
            checks++;
            if (e.t != tick) begin
                failures++;
                $display("FAIL %s missed: sampled at tick %0d, due %0d", e.name, tick, e.t);
            end else begin
                case (e.kind)
                    0:       act = int'(ce_out[e.idx]);
                    1:       act = int'(clk_out[e.idx]);
                    2:       act = int'(locked);
                    3:       act = int'(cfg_ready);
                    4:       act = int'(cfg_err);
                    default: act = ce1_cnt;
                endcase
                if (act != e.val) begin
                    failures++;
                    $display("FAIL %s got=%0d exp=%0d", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_chan = 3'd0; cfg_inc = '0;
        repeat (2) @(posedge refclk);
        #1;
        // reset state, sampled after edge 3 which still sees rst=0
        ex(3, 0, 0, 0); ex(3, 0, 1, 0); ex(3, 1, 0, 0); ex(3, 1, 1, 0);
        ex(3, 2, 0, 0); ex(3, 3, 0, 1); ex(3, 4, 0, 0);
        @(posedge refclk);
        #1;
        t0  = tick;
        rst = 1'b1;

        // defaults: ch0 half-rate, ch1 3756093/2^24
        for (int k = 1; k <= 6; k++) begin
            ex(k, 0, 0, (k % 2 == 0) ? 1 : 0);
            ex(k, 1, 0, k % 2);
        end
        ex(1, 1, 1, 0); ex(2, 1, 1, 0); ex(3, 1, 1, 1); ex(4, 1, 1, 1); ex(5, 1, 1, 0);
        ex(4, 0, 1, 0); ex(5, 0, 1, 1);
        ex(15, 2, 0, 0); ex(16, 2, 0, 1); ex(100, 2, 0, 1);
        ex(100, 5, 1, 22);
        go_to(100);

        // reprogram ch0 to quarter rate mid-period
        ex(100, 3, 0, 1);
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_inc = 24'd4194304;
        ex(101, 0, 0, 0); ex(101, 1, 0, 1); ex(101, 3, 0, 0); ex(101, 2, 0, 1);
        ex(102, 0, 0, 1); ex(102, 1, 0, 0); ex(102, 3, 0, 1); ex(102, 2, 0, 0);
        ex(103, 0, 0, 0); ex(103, 1, 0, 0);
        ex(104, 0, 0, 0); ex(104, 1, 0, 1);
        ex(105, 0, 0, 0); ex(105, 1, 0, 1);
        ex(106, 0, 0, 1); ex(106, 1, 0, 0);
        ex(108, 1, 0, 1); ex(110, 0, 0, 1);
        ex(117, 2, 0, 0); ex(118, 2, 0, 1);
        go_to(101);
        cfg_valid = 1'b0;
        go_to(120);

        // out-of-range channel
        cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_inc = 24'd7;
        ex(120, 3, 0, 1);
        ex(121, 4, 0, 1); ex(122, 4, 0, 0); ex(123, 4, 0, 0);
        ex(122, 0, 0, 1); ex(124, 0, 0, 0); ex(126, 0, 0, 1); ex(122, 2, 0, 1);
        go_to(121);
        cfg_valid = 1'b0; cfg_chan = 3'd0;
        go_to(130);

        // stop ch1; its carries fall at edges 130 and 135
        ex(130, 0, 1, 1);
        cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_inc = 24'd0;
        ex(131, 3, 0, 0); ex(134, 3, 0, 0); ex(135, 3, 0, 1);
        for (int k = 131; k <= 134; k++) ex(k, 0, 1, 0);
        ex(135, 0, 1, 1); ex(135, 2, 0, 0);
        for (int k = 136; k <= 140; k++) ex(k, 0, 1, 0);
        ex(139, 1, 1, 0);
        go_to(131);
        cfg_valid = 1'b0;
        go_to(140);

        // restart ch1 while stopped
        cfg_valid = 1'b1; cfg_inc = 24'd8388608;
        ex(141, 3, 0, 0); ex(142, 3, 0, 1); ex(142, 2, 0, 0);
        ex(141, 0, 1, 0); ex(142, 0, 1, 0); ex(143, 0, 1, 0);
        ex(142, 1, 1, 0); ex(143, 1, 1, 1);
        ex(144, 0, 1, 1); ex(144, 1, 1, 0);
        ex(145, 0, 1, 0); ex(145, 1, 1, 1); ex(146, 0, 1, 1);
        go_to(141);
        cfg_valid = 1'b0;
        go_to(150);

        // sync with a pending ch0 write
        ex(150, 0, 0, 1);
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_inc = 24'd8388608;
        ex(151, 3, 0, 0);
        for (int c = 0; c < 2; c++) begin
            ex(152, 0, c, 0); ex(152, 1, c, 0);
            ex(153, 0, c, 0); ex(153, 1, c, 1);
            ex(154, 0, c, 1); ex(154, 1, c, 0);
            ex(155, 0, c, 0); ex(155, 1, c, 1);
        end
        ex(152, 2, 0, 0); ex(152, 3, 0, 1);
        ex(167, 2, 0, 0); ex(168, 2, 0, 1);
        go_to(151);
        cfg_valid = 1'b0; sync = 1'b1;
        go_to(152);
        sync = 1'b0;
        go_to(170);

        // reset while a write is pending
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_inc = 24'd4194304;
        ex(171, 3, 0, 0);
        ex(172, 0, 0, 0); ex(172, 0, 1, 0); ex(172, 1, 0, 0); ex(172, 1, 1, 0);
        ex(172, 2, 0, 0); ex(172, 3, 0, 1); ex(172, 4, 0, 0);
        ex(173, 0, 0, 0); ex(173, 1, 0, 1);
        ex(174, 0, 0, 1); ex(174, 1, 0, 0); ex(174, 3, 0, 1);
        ex(175, 0, 0, 0); ex(175, 1, 0, 1); ex(175, 1, 1, 1);
        ex(176, 0, 0, 1);
        ex(187, 2, 0, 0); ex(188, 2, 0, 1);
        go_to(171);
        cfg_valid = 1'b0; rst = 1'b0;
        go_to(172);
        rst = 1'b1;
        go_to(190);

        done = 1'b1;
        repeat (2) @(negedge refclk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
